// File: rtl/s2p_pkg.sv
// Shared constants and FSM state encoding for the serial-to-parallel frame receiver.
package s2p_pkg;

    localparam int unsigned S2P_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } s2p_state_e;

endpackage

// File: rtl/s2p_shift.sv
// LSB-first deserialising shift register: new bits enter at the MSB and walk down,
// so after WIDTH shifts the first received bit sits in bit 0.
module s2p_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (shift_i) begin
            data_q <= {bit_i, data_q[WIDTH-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional even parity,
// stop bit; delivers words over a valid/ready handshake with error/overrun pulses.
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_W    = S2P_DATA_W,
    parameter int unsigned PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_in,
    input  logic              en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] par_out,
    output logic              out_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    s2p_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    logic              sh_clr;
    logic              sh_shift;
    logic              commit;
    logic              hs;
    logic [DATA_W-1:0] sh_data;

    s2p_shift #(
        .WIDTH (DATA_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (sh_clr),
        .shift_i (sh_shift),
        .bit_i   (ser_in),
        .data_o  (sh_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            par_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    // Frame sequencing only advances on enabled edges; the handshake does not depend on en.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        par_d    = par_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        ovr_d    = 1'b0;
        sh_clr   = 1'b0;
        sh_shift = 1'b0;
        commit   = 1'b0;
        hs       = valid_q & out_ready;

        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!ser_in) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        bad_d   = 1'b0;
                        sh_clr  = 1'b1;
                    end
                end
                ST_DATA: begin
                    sh_shift = 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (ser_in != (^sh_data)) begin
                        perr_d = 1'b1;
                        bad_d  = 1'b1;
                    end
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (ser_in) begin
                        commit  = ~bad_q;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (ser_in) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A commit only lands if the output slot is free or being emptied on this edge.
        if (commit) begin
            if (!valid_q || hs) begin
                par_d   = sh_data;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign par_out    = par_q;
    assign out_valid  = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: two instances (no parity / even parity) fed from line queues,
// checked every cycle against a frame-level model plus directed literal expectations.
module tb_s2p_frame_ctrl;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              out_ready;
    logic              ser0, ser1;
    logic [DATA_W-1:0] par0, par1;
    logic              v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    s2p_frame_ctrl #(.DATA_W(DATA_W), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(reset), .ser_in(ser0), .en(en), .out_ready(out_ready),
        .par_out(par0), .out_valid(v0), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .busy(b0)
    );

    s2p_frame_ctrl #(.DATA_W(DATA_W), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .ser_in(ser1), .en(en), .out_ready(out_ready),
        .par_out(par1), .out_valid(v1), .frame_err(fe1), .parity_err(pe1),
        .overrun(ov1), .busy(b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: mode 0 = line idle, 1 = collecting frame bits, 2 = waiting out a break.
    int                m_mode [2];
    int                m_n    [2];
    bit                m_bits [2][0:DATA_W+1];
    logic [DATA_W-1:0] m_par  [2];
    bit                m_valid[2];
    bit                m_ferr [2];
    bit                m_perr [2];
    bit                m_ovr  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_n[k] = 0; m_par[k] = '0;
            m_valid[k] = 0; m_ferr[k] = 0; m_perr[k] = 0; m_ovr[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input bit s);
        bit                hs;
        bit                commit;
        bit                good;
        logic [DATA_W-1:0] w;
        hs = m_valid[k] && out_ready;
        commit = 0;
        w = '0;
        m_ferr[k] = 0; m_perr[k] = 0; m_ovr[k] = 0;
        if (en) begin
            if (m_mode[k] == 0) begin
                if (!s) begin m_mode[k] = 1; m_n[k] = 0; end
            end else if (m_mode[k] == 2) begin
                if (s) m_mode[k] = 0;
            end else begin
                m_bits[k][m_n[k]] = s;
                m_n[k]++;
                for (int i = 0; i < DATA_W; i++) w[i] = m_bits[k][i];
                if (k == 1 && m_n[k] == DATA_W + 1) m_perr[k] = (s != ^w);
                if (m_n[k] == DATA_W + 1 + k) begin
                    good = (k == 0) || (m_bits[k][DATA_W] == ^w);
                    if (s) begin
                        m_mode[k] = 0;
                        commit = good;
                    end else begin
                        m_ferr[k] = 1;
                        m_mode[k] = 2;
                    end
                end
            end
        end
        if (commit) begin
            if (!m_valid[k] || hs) begin m_par[k] = w; m_valid[k] = 1; end
            else m_ovr[k] = 1;
        end else if (hs) begin
            m_valid[k] = 0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else begin
            model_edge(0, ser0);
            model_edge(1, ser1);
        end
    end

    // Per-cycle comparison of both instances against the model, plus pulse tallies.
    int fe_cnt0 = 0, ov_cnt0 = 0, pe_cnt1 = 0;

    always @(negedge clk) begin
        if (fe0) fe_cnt0++;
        if (ov0) ov_cnt0++;
        if (pe1) pe_cnt1++;
        if (cmp_on) begin
            check("par0",  32'(par0), 32'(m_par[0]));
            check("v0",    32'(v0),   32'(m_valid[0]));
            check("fe0",   32'(fe0),  32'(m_ferr[0]));
            check("pe0",   32'(pe0),  32'(1'b0));
            check("ov0",   32'(ov0),  32'(m_ovr[0]));
            check("busy0", 32'(b0),   32'(m_mode[0] != 0));
            check("par1",  32'(par1), 32'(m_par[1]));
            check("v1",    32'(v1),   32'(m_valid[1]));
            check("fe1",   32'(fe1),  32'(m_ferr[1]));
            check("pe1",   32'(pe1),  32'(m_perr[1]));
            check("ov1",   32'(ov1),  32'(m_ovr[1]));
            check("busy1", 32'(b1),   32'(m_mode[1] != 0));
        end
    end

    // Line stimulus: one queue of line levels per instance, consumed only on en=1 edges.
    bit q0[$];
    bit q1[$];

    task automatic push(input int k, input bit b);
        if (k == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic add_frame(input int k, input logic [DATA_W-1:0] w, input bit flip,
                             input bit stop_v, input int brk, input int gap);
        push(k, 1'b0);
        for (int i = 0; i < DATA_W; i++) push(k, w[i]);
        if (k == 1) push(k, (^w) ^ flip);
        push(k, stop_v);
        for (int i = 0; i < brk; i++) push(k, 1'b0);
        for (int i = 0; i < gap; i++) push(k, 1'b1);
    endtask

    task automatic add_both(input logic [DATA_W-1:0] w, input bit stop_v, input int brk, input int gap);
        add_frame(0, w, 1'b0, stop_v, brk, gap);
        add_frame(1, w, 1'b0, stop_v, brk, gap);
    endtask

    // en_mode: 0 always on, 1 toggle, 2 random; rdy_mode: 0 low, 1 high, 2 random.
    task automatic run_stream(input int en_mode, input int rdy_mode);
        int cyc  = 0;
        int idle = 0;
        bit t    = 1'b1;
        while ((q0.size() > 0 || q1.size() > 0 || idle < 2) && cyc < 20000) begin
            @(negedge clk);
            case (en_mode)
                0:       en = 1'b1;
                1:       begin en = t; t = ~t; end
                default: en = ($urandom_range(0, 9) < 7);
            endcase
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = $urandom_range(0, 1) != 0;
            endcase
            ser0 = (q0.size() > 0) ? q0[0] : 1'b1;
            ser1 = (q1.size() > 0) ? q1[0] : 1'b1;
            @(posedge clk);
            if (en) begin
                if (q0.size() > 0) void'(q0.pop_front());
                if (q1.size() > 0) void'(q1.pop_front());
                if (q0.size() == 0 && q1.size() == 0) idle++;
            end
            cyc++;
        end
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got %0d cycles expected < 20000", cyc);
        end
    endtask

    int snap;
    logic [DATA_W-1:0] rw;
    logic [DATA_W-1:0] a5 = 8'hA5;

    initial begin
        reset = 1'b0; en = 1'b0; out_ready = 1'b0; ser0 = 1'b1; ser1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_par0", 32'(par0), 32'h0);
        check("rst_v0",   32'(v0),   32'h0);
        check("rst_busy", 32'({b0, b1}), 32'h0);
        reset = 1'b1;
        cmp_on = 1'b1;

        // 0xA5 with a ready consumer
        add_both(a5, 1'b1, 0, 2);
        run_stream(0, 1);
        check("a5_par0", 32'(par0), 32'hA5);
        check("a5_par1", 32'(par1), 32'hA5);

        // back-to-back 0x3C, 0xC3 with stalled consumer
        snap = ov_cnt0;
        add_both(8'h3C, 1'b1, 0, 0);
        add_both(8'hC3, 1'b1, 0, 1);
        run_stream(0, 0);
        @(negedge clk);
        check("b2b_par0",    32'(par0), 32'h3C);
        check("b2b_v0",      32'(v0),   32'h1);
        check("b2b_overrun", 32'(ov_cnt0 - snap), 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_drain_v0", 32'(v0), 32'h0);

        // bad stop bit, line low for a further 3 cycles, then 0x01
        snap = fe_cnt0;
        add_both(8'h5A, 1'b0, 3, 1);
        add_both(8'h01, 1'b1, 0, 1);
        run_stream(0, 1);
        check("brk_ferr", 32'(fe_cnt0 - snap), 32'h1);
        check("brk_par0", 32'(par0), 32'h01);

        // parity instance: wrong parity then correct
        snap = pe_cnt1;
        add_frame(1, 8'h07, 1'b1, 1'b1, 0, 1);
        add_frame(0, 8'h70, 1'b0, 1'b1, 0, 1);
        run_stream(0, 1);
        check("par_perr", 32'(pe_cnt1 - snap), 32'h1);
        check("par_nocommit", 32'(par1), 32'h01);
        add_frame(1, 8'h07, 1'b0, 1'b1, 0, 1);
        run_stream(0, 1);
        check("par_ok", 32'(par1), 32'h07);

        // reset after start bit and four data bits
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en = 1'b1; ser0 = (i == 0) ? 1'b0 : 1'b1; ser1 = ser0;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_par",  32'({par0, par1}), 32'h0);
        check("mid_rst_busy", 32'({b0, b1, v0, v1}), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        add_both(8'hFF, 1'b1, 0, 1);
        run_stream(0, 1);
        check("ff_par0", 32'(par0), 32'hFF);

        // en toggling every cycle
        add_both(8'h81, 1'b1, 0, 1);
        run_stream(1, 1);
        check("en_tog_par0", 32'(par0), 32'h81);
        check("en_tog_par1", 32'(par1), 32'h81);

        // randomized frames with random errors, gaps, enables and back-pressure
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 2; k++) begin
                bit stp;
                int brk;
                rw  = DATA_W'($urandom);
                stp = ($urandom_range(0, 7) != 0);
                brk = stp ? 0 : $urandom_range(0, 2);
                add_frame(k, rw, ($urandom_range(0, 7) == 0), stp, brk,
                          stp ? $urandom_range(0, 2) : $urandom_range(1, 2));
            end
        end
        run_stream(2, 2);
        repeat (3) @(negedge clk);

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s2p_frame_ctrl.md
S2P_FRAME_CTRL -- requirements
Module: s2p_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ser_in  input  1  serial line; idle high; one bit per clk when en=1.
REQ-006 en  input  1  bit-sample enable; when 0, all state holds.
REQ-007 par_out  output  DATA_W  last accepted word; first received bit in bit 0.
REQ-008 out_valid  output  1  par_out holds a word not yet taken.
REQ-009 out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-011 parity_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only).
REQ-012 overrun  output  1  one-cycle pulse: good frame dropped because out_valid was still 1.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP, BREAK; it SHALL advance only on edges where en=1.
REQ-015 IDLE: ser_in=0 -> DATA with the bit counter cleared; ser_in=1 -> stay in IDLE.
REQ-016 DATA: shift ser_in into the shift register LSB-first; after DATA_W samples -> PARITY if PARITY_EN=1, else -> STOP.
REQ-017 PARITY: compare ser_in with the XOR of the data bits; on mismatch, pulse parity_err and mark the frame bad; -> STOP.
REQ-018 STOP: ser_in=1 and frame good -> commit; ser_in=1 and frame bad -> discard, -> IDLE; ser_in=0 -> pulse frame_err, discard, -> BREAK.
REQ-019 BREAK: stay until ser_in=1 is sampled, then -> IDLE; a low line in BREAK is never taken as a start bit.
REQ-020 Commit: on the same edge that samples the stop bit, load par_out and set out_valid, provided out_valid is 0 or a handshake occurs on that edge; latency from stop-bit sample to out_valid is 0 cycles (registered on that edge).
REQ-021 Commit with out_valid=1 and out_ready=0: par_out and out_valid hold; overrun pulses; the new word is lost.
REQ-022 A handshake with no commit on that edge SHALL clear out_valid; par_out SHALL hold its last value.
REQ-023 The handshake SHALL operate regardless of en.
REQ-024 Error pulses SHALL last exactly one clk and be registered outputs.
REQ-025 Back-to-back frames (start bit on the cycle after the stop bit) SHALL be received without loss.
REQ-026 The bit counter width SHALL be clog2(DATA_W+1); the counter SHALL never wrap inside a frame.

Reset
REQ-027 reset low SHALL immediately force: FSM=IDLE, counter=0, shift register=0, par_out=0, out_valid=0, all error pulses=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no commit and no error pulse; reception resumes on the first start bit after release.
REQ-029 Deassertion is synchronised externally; the block adds no reset synchroniser.

Structure
REQ-030 Package s2p_pkg SHALL hold the FSM state enum and the DATA_W default constant.
REQ-031 Sub-module s2p_shift SHALL hold the enabled LSB-first DATA_W shift register with synchronous clear; the controller instantiates it once.
REQ-032 No latches; all outputs registered.

Verification
REQ-033 Idle-high line, then 0, bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), then 1, with out_ready=1 -> par_out=0xA5, out_valid high for one cycle on the stop edge, no errors.
REQ-034 Two back-to-back frames 0x3C and 0xC3 with out_ready=0 -> par_out=0x3C, out_valid held high, overrun pulses once at the second stop; then out_ready=1 -> out_valid=0.
REQ-035 Frame 0x5A with stop bit 0, line held low 3 cycles -> frame_err pulses once, out_valid stays 0, FSM in BREAK until ser_in=1, then the next frame 0x01 is received correctly.
REQ-036 PARITY_EN=1: frame 0x07 with parity bit 0 (expected 1) -> parity_err pulses, no commit; then a correct 0x07 frame with parity 1 -> par_out=0x07.
REQ-037 reset pulled low after 4 data bits -> outputs zero immediately, busy=0; the following frame 0xFF commits correctly.
REQ-038 en toggling 1/0 every cycle during frame 0x81 -> par_out=0x81, with bits counted only on en=1 edges.
